// File: rtl/tl_pkg.sv
// Shared TL-UL definitions for the CDC master arbiter slice: widths, opcodes,
// the channel-A payload type and the arbiter state encoding.
package tl_pkg;

  localparam int unsigned TL_AW    = 32;
  localparam int unsigned TL_DW    = 32;
  localparam int unsigned TL_MW    = TL_DW / 8;
  localparam int unsigned TL_OPW   = 3;
  localparam int unsigned TL_PW    = 3;
  localparam int unsigned TL_SW    = 3;
  localparam int unsigned TL_CNT_W = 4;

  localparam logic [TL_OPW-1:0] TL_OP_GET             = 3'd4;
  localparam logic [TL_OPW-1:0] TL_OP_PUT_FULL        = 3'd0;
  localparam logic [TL_OPW-1:0] TL_OP_PUT_PARTIAL     = 3'd1;
  localparam logic [TL_OPW-1:0] TL_OP_ACCESS_ACK      = 3'd0;
  localparam logic [TL_OPW-1:0] TL_OP_ACCESS_ACK_DATA = 3'd1;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_HOLD = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic [TL_OPW-1:0] opcode;
    logic [TL_PW-1:0]  param;
    logic [TL_SW-1:0]  size;
    logic [TL_AW-1:0]  address;
    logic [TL_MW-1:0]  mask;
    logic [TL_DW-1:0]  data;
  } tl_a_t;

endpackage

// File: rtl/tl_credit_counter.sv
// Per-master outstanding-request counter: saturating at MAX, never below zero,
// with a full flag that blocks further grants.
module tl_credit_counter
  import tl_pkg::*;
#(
  parameter int unsigned MAX = 4,
  parameter int unsigned W   = TL_CNT_W
) (
  input  logic         clk_in,
  input  logic         reset_in,
  input  logic         inc_i,
  input  logic         dec_i,
  output logic [W-1:0] cnt_o,
  output logic         full_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Simultaneous inc and dec cancel out
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && !dec_i && (cnt_q < W'(MAX))) begin
      cnt_d = cnt_q + W'(1);
    end else if (dec_i && !inc_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign full_o = (cnt_q >= W'(MAX));

endmodule

// File: rtl/tl_cdc_master_arbiter.sv
// Two-master TL-UL arbiter in front of the 100/24 MHz CDC adapter.
// Define TL_ARB_FIXED_PRIO_EN for fixed M0 priority; default is round-robin.
module tl_cdc_master_arbiter
  import tl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = TL_AW,
  parameter int unsigned DATA_WIDTH      = TL_DW,
  parameter int unsigned MASK_WIDTH      = DATA_WIDTH / 8,
  parameter int unsigned OPCODE_WIDTH    = TL_OPW,
  parameter int unsigned PARAM_WIDTH     = TL_PW,
  parameter int unsigned SIZE_WIDTH      = TL_SW,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                    clk_in,
  input  logic                    reset_in,
  input  logic                    m0_a_valid,
  output logic                    m0_a_ready,
  input  logic [OPCODE_WIDTH-1:0] m0_a_opcode,
  input  logic [PARAM_WIDTH-1:0]  m0_a_param,
  input  logic [SIZE_WIDTH-1:0]   m0_a_size,
  input  logic [ADDR_WIDTH-1:0]   m0_a_address,
  input  logic [MASK_WIDTH-1:0]   m0_a_mask,
  input  logic [DATA_WIDTH-1:0]   m0_a_data,
  output logic                    m0_d_valid,
  input  logic                    m0_d_ready,
  output logic [OPCODE_WIDTH-1:0] m0_d_opcode,
  output logic [PARAM_WIDTH-1:0]  m0_d_param,
  output logic [SIZE_WIDTH-1:0]   m0_d_size,
  output logic [DATA_WIDTH-1:0]   m0_d_data,
  output logic                    m0_d_error,
  input  logic                    m1_a_valid,
  output logic                    m1_a_ready,
  input  logic [OPCODE_WIDTH-1:0] m1_a_opcode,
  input  logic [PARAM_WIDTH-1:0]  m1_a_param,
  input  logic [SIZE_WIDTH-1:0]   m1_a_size,
  input  logic [ADDR_WIDTH-1:0]   m1_a_address,
  input  logic [MASK_WIDTH-1:0]   m1_a_mask,
  input  logic [DATA_WIDTH-1:0]   m1_a_data,
  output logic                    m1_d_valid,
  input  logic                    m1_d_ready,
  output logic [OPCODE_WIDTH-1:0] m1_d_opcode,
  output logic [PARAM_WIDTH-1:0]  m1_d_param,
  output logic [SIZE_WIDTH-1:0]   m1_d_size,
  output logic [DATA_WIDTH-1:0]   m1_d_data,
  output logic                    m1_d_error,
  output logic                    a_valid_out,
  input  logic                    a_ready_out,
  output logic [OPCODE_WIDTH-1:0] a_opcode_out,
  output logic [PARAM_WIDTH-1:0]  a_param_out,
  output logic [SIZE_WIDTH-1:0]   a_size_out,
  output logic [ADDR_WIDTH-1:0]   a_address_out,
  output logic [MASK_WIDTH-1:0]   a_mask_out,
  output logic [DATA_WIDTH-1:0]   a_data_out,
  output logic                    a_source_out,
  input  logic                    d_valid_in,
  output logic                    d_ready_in,
  input  logic [OPCODE_WIDTH-1:0] d_opcode_in,
  input  logic [PARAM_WIDTH-1:0]  d_param_in,
  input  logic [SIZE_WIDTH-1:0]   d_size_in,
  input  logic [DATA_WIDTH-1:0]   d_data_in,
  input  logic                    d_error_in,
  input  logic                    d_source_in,
  output logic                    unexpected_resp
);

  arb_state_e          state_q, state_d;
  tl_a_t               a_q, a_d;
  logic                a_valid_q, a_source_q, unexp_q;
  logic                grant0, grant1, a_fire;
  logic                elig0, elig1, full0, full1;
  logic                dec0, dec1, d_sel_zero, d_hs;
  logic [TL_CNT_W-1:0] cnt0, cnt1;
`ifndef TL_ARB_FIXED_PRIO_EN
  logic                rr_ptr_q;
`endif

  assign elig0 = m0_a_valid & ~full0;
  assign elig1 = m1_a_valid & ~full1;

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state_q <= ARB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE: if (elig0 || elig1) state_d = ARB_HOLD;
      ARB_HOLD: if (a_ready_out)    state_d = ARB_IDLE;
      default:                      state_d = ARB_IDLE;
    endcase
  end

  // Grants exist only in IDLE, which caps throughput at one request per two cycles
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state_q == ARB_IDLE) begin
`ifdef TL_ARB_FIXED_PRIO_EN
      grant0 = elig0;
      grant1 = elig1 & ~elig0;
`else
      if (!rr_ptr_q) begin
        grant0 = elig0;
        grant1 = elig1 & ~elig0;
      end else begin
        grant1 = elig1;
        grant0 = elig0 & ~elig1;
      end
`endif
    end
    a_fire = grant0 | grant1;
  end

  assign m0_a_ready = grant0;
  assign m1_a_ready = grant1;

  always_comb begin
    a_d.opcode  = grant1 ? TL_OPW'(m1_a_opcode)  : TL_OPW'(m0_a_opcode);
    a_d.param   = grant1 ? TL_PW'(m1_a_param)    : TL_PW'(m0_a_param);
    a_d.size    = grant1 ? TL_SW'(m1_a_size)     : TL_SW'(m0_a_size);
    a_d.address = grant1 ? TL_AW'(m1_a_address)  : TL_AW'(m0_a_address);
    a_d.mask    = grant1 ? TL_MW'(m1_a_mask)     : TL_MW'(m0_a_mask);
    a_d.data    = grant1 ? TL_DW'(m1_a_data)     : TL_DW'(m0_a_data);
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      a_valid_q  <= 1'b0;
      a_q        <= '0;
      a_source_q <= 1'b0;
      unexp_q    <= 1'b0;
`ifndef TL_ARB_FIXED_PRIO_EN
      rr_ptr_q   <= 1'b0;
`endif
    end else begin
      if (a_fire) begin
        a_q        <= a_d;
        a_source_q <= grant1;
        a_valid_q  <= 1'b1;
`ifndef TL_ARB_FIXED_PRIO_EN
        rr_ptr_q   <= grant0;
`endif
      end else if ((state_q == ARB_HOLD) && a_ready_out) begin
        a_valid_q <= 1'b0;
      end
      if (d_valid_in && d_sel_zero) begin
        unexp_q <= 1'b1;
      end
    end
  end

  assign a_valid_out     = a_valid_q;
  assign a_opcode_out    = OPCODE_WIDTH'(a_q.opcode);
  assign a_param_out     = PARAM_WIDTH'(a_q.param);
  assign a_size_out      = SIZE_WIDTH'(a_q.size);
  assign a_address_out   = ADDR_WIDTH'(a_q.address);
  assign a_mask_out      = MASK_WIDTH'(a_q.mask);
  assign a_data_out      = DATA_WIDTH'(a_q.data);
  assign a_source_out    = a_source_q;
  assign unexpected_resp = unexp_q;

  // Responses for a master with nothing in flight are swallowed and flagged
  assign d_sel_zero = d_source_in ? (cnt1 == '0) : (cnt0 == '0);
  assign d_ready_in = d_sel_zero | (d_source_in ? m1_d_ready : m0_d_ready);
  assign d_hs       = d_valid_in & d_ready_in & ~d_sel_zero;
  assign dec0       = d_hs & ~d_source_in;
  assign dec1       = d_hs & d_source_in;
  assign m0_d_valid = d_valid_in & ~d_source_in & (cnt0 != '0);
  assign m1_d_valid = d_valid_in & d_source_in & (cnt1 != '0);

  assign m0_d_opcode = d_opcode_in;
  assign m0_d_param  = d_param_in;
  assign m0_d_size   = d_size_in;
  assign m0_d_data   = d_data_in;
  assign m0_d_error  = d_error_in;
  assign m1_d_opcode = d_opcode_in;
  assign m1_d_param  = d_param_in;
  assign m1_d_size   = d_size_in;
  assign m1_d_data   = d_data_in;
  assign m1_d_error  = d_error_in;

  tl_credit_counter #(.MAX(MAX_OUTSTANDING), .W(TL_CNT_W)) u_cred0 (
    .clk_in   (clk_in),
    .reset_in (reset_in),
    .inc_i    (grant0),
    .dec_i    (dec0),
    .cnt_o    (cnt0),
    .full_o   (full0)
  );

  tl_credit_counter #(.MAX(MAX_OUTSTANDING), .W(TL_CNT_W)) u_cred1 (
    .clk_in   (clk_in),
    .reset_in (reset_in),
    .inc_i    (grant1),
    .dec_i    (dec1),
    .cnt_o    (cnt1),
    .full_o   (full1)
  );

endmodule

// File: tb/tb_tl_cdc_master_arbiter.sv
// Bench for tl_cdc_master_arbiter: cycle model plus channel-A scoreboard and
// directed scenarios for grants, hold, credits, unexpected responses and reset.
module tb_tl_cdc_master_arbiter;

  localparam int MAXO = 4;

  logic        clk_in, reset_in;
  logic        m0_a_valid, m0_a_ready, m1_a_valid, m1_a_ready;
  logic [2:0]  m0_a_opcode, m0_a_param, m0_a_size, m1_a_opcode, m1_a_param, m1_a_size;
  logic [31:0] m0_a_address, m0_a_data, m1_a_address, m1_a_data;
  logic [3:0]  m0_a_mask, m1_a_mask;
  logic        m0_d_valid, m0_d_ready, m0_d_error, m1_d_valid, m1_d_ready, m1_d_error;
  logic [2:0]  m0_d_opcode, m0_d_param, m0_d_size, m1_d_opcode, m1_d_param, m1_d_size;
  logic [31:0] m0_d_data, m1_d_data;
  logic        a_valid_out, a_ready_out, a_source_out;
  logic [2:0]  a_opcode_out, a_param_out, a_size_out;
  logic [31:0] a_address_out, a_data_out;
  logic [3:0]  a_mask_out;
  logic        d_valid_in, d_ready_in, d_error_in, d_source_in, unexpected_resp;
  logic [2:0]  d_opcode_in, d_param_in, d_size_in;
  logic [31:0] d_data_in;

  tl_cdc_master_arbiter #(.MAX_OUTSTANDING(MAXO)) dut (
    .clk_in(clk_in), .reset_in(reset_in),
    .m0_a_valid(m0_a_valid), .m0_a_ready(m0_a_ready), .m0_a_opcode(m0_a_opcode),
    .m0_a_param(m0_a_param), .m0_a_size(m0_a_size), .m0_a_address(m0_a_address),
    .m0_a_mask(m0_a_mask), .m0_a_data(m0_a_data),
    .m0_d_valid(m0_d_valid), .m0_d_ready(m0_d_ready), .m0_d_opcode(m0_d_opcode),
    .m0_d_param(m0_d_param), .m0_d_size(m0_d_size), .m0_d_data(m0_d_data), .m0_d_error(m0_d_error),
    .m1_a_valid(m1_a_valid), .m1_a_ready(m1_a_ready), .m1_a_opcode(m1_a_opcode),
    .m1_a_param(m1_a_param), .m1_a_size(m1_a_size), .m1_a_address(m1_a_address),
    .m1_a_mask(m1_a_mask), .m1_a_data(m1_a_data),
    .m1_d_valid(m1_d_valid), .m1_d_ready(m1_d_ready), .m1_d_opcode(m1_d_opcode),
    .m1_d_param(m1_d_param), .m1_d_size(m1_d_size), .m1_d_data(m1_d_data), .m1_d_error(m1_d_error),
    .a_valid_out(a_valid_out), .a_ready_out(a_ready_out), .a_opcode_out(a_opcode_out),
    .a_param_out(a_param_out), .a_size_out(a_size_out), .a_address_out(a_address_out),
    .a_mask_out(a_mask_out), .a_data_out(a_data_out), .a_source_out(a_source_out),
    .d_valid_in(d_valid_in), .d_ready_in(d_ready_in), .d_opcode_in(d_opcode_in),
    .d_param_in(d_param_in), .d_size_in(d_size_in), .d_data_in(d_data_in),
    .d_error_in(d_error_in), .d_source_in(d_source_in), .unexpected_resp(unexpected_resp)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic        src;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
  } a_exp_t;

  a_exp_t a_q[$];
  bit     m_state, m_rr, m_unexp, g0, g1;
  int     m_cnt[2];
  int     gnt_cnt[2];

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  // Reference model: expectations on the falling edge, state update on the rising edge
  always @(negedge clk_in) begin
    bit e0, e1, sel, zero;
    a_exp_t ex;
    e0 = m0_a_valid && (m_cnt[0] < MAXO);
    e1 = m1_a_valid && (m_cnt[1] < MAXO);
    g0 = 1'b0;
    g1 = 1'b0;
    if (!m_state) begin
`ifdef TL_ARB_FIXED_PRIO_EN
      g0 = e0; g1 = e1 && !e0;
`else
      if (!m_rr) begin g0 = e0; g1 = e1 && !e0; end
      else       begin g1 = e1; g0 = e0 && !e1; end
`endif
    end
    chk("m0_a_ready", 64'(m0_a_ready), 64'(g0));
    chk("m1_a_ready", 64'(m1_a_ready), 64'(g1));
    chk("a_valid_out", 64'(a_valid_out), 64'(m_state));
    chk("unexpected_resp", 64'(unexpected_resp), 64'(m_unexp));
    if (m_state) begin
      if (a_q.size() == 0) begin
        chk("a_queue_underflow", 64'(0), 64'(1));
      end else begin
        ex = a_q[0];
        chk("a_source_out", 64'(a_source_out), 64'(ex.src));
        chk("a_opcode_out", 64'(a_opcode_out), 64'(ex.op));
        chk("a_address_out", 64'(a_address_out), 64'(ex.addr));
        chk("a_data_out", 64'(a_data_out), 64'(ex.data));
        chk("a_mask_out", 64'(a_mask_out), 64'(ex.mask));
        if (a_ready_out) void'(a_q.pop_front());
      end
    end
    if ((g0 || g1) && !reset_in) begin
      ex.src  = g1;
      ex.op   = g1 ? m1_a_opcode  : m0_a_opcode;
      ex.addr = g1 ? m1_a_address : m0_a_address;
      ex.data = g1 ? m1_a_data    : m0_a_data;
      ex.mask = g1 ? m1_a_mask    : m0_a_mask;
      a_q.push_back(ex);
      if (g0) gnt_cnt[0]++;
      if (g1) gnt_cnt[1]++;
    end
    sel  = d_source_in;
    zero = (m_cnt[sel] == 0);
    chk("m0_d_valid", 64'(m0_d_valid), 64'(d_valid_in && !sel && !zero));
    chk("m1_d_valid", 64'(m1_d_valid), 64'(d_valid_in && sel && !zero));
    if (d_valid_in) begin
      chk("d_ready_in", 64'(d_ready_in), 64'(zero || (sel ? m1_d_ready : m0_d_ready)));
      chk("d_data_fanout", 64'(sel ? m1_d_data : m0_d_data), 64'(d_data_in));
    end
  end

  always @(posedge clk_in or posedge reset_in) begin
    bit sel, hs;
    if (reset_in) begin
      m_state = 1'b0; m_rr = 1'b0; m_unexp = 1'b0;
      m_cnt[0] = 0; m_cnt[1] = 0;
      a_q.delete();
    end else begin
      sel = d_source_in;
      hs  = d_valid_in && (m_cnt[sel] != 0) && (sel ? m1_d_ready : m0_d_ready);
      if (d_valid_in && (m_cnt[sel] == 0)) m_unexp = 1'b1;
      m_cnt[0] = m_cnt[0] + int'(g0) - int'(hs && !sel);
      m_cnt[1] = m_cnt[1] + int'(g1) - int'(hs && sel);
      if (!m_state && (g0 || g1)) begin
        m_state = 1'b1;
        m_rr    = g0;
      end else if (m_state && a_ready_out) begin
        m_state = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset();
    reset_in = 1'b1;
    tick();
    reset_in = 1'b0;
    tick();
    gnt_cnt[0] = 0;
    gnt_cnt[1] = 0;
  endtask

  initial begin
    reset_in = 1'b1;
    {m0_a_valid, m1_a_valid, a_ready_out, d_valid_in, d_source_in, d_error_in} = '0;
    m0_d_ready = 1'b1; m1_d_ready = 1'b1;
    m0_a_opcode = 3'd4; m0_a_param = '0; m0_a_size = 3'd2; m0_a_mask = 4'hF; m0_a_data = 32'h0;
    m1_a_opcode = 3'd0; m1_a_param = '0; m1_a_size = 3'd2; m1_a_mask = 4'h3; m1_a_data = 32'hA5A5_0001;
    m0_a_address = '0; m1_a_address = '0;
    d_opcode_in = 3'd1; d_param_in = '0; d_size_in = 3'd2; d_data_in = '0;
    repeat (2) tick();
    chk("rst_a_valid", 64'(a_valid_out), 64'(0));
    chk("rst_a_address", 64'(a_address_out), 64'(0));
    chk("rst_unexpected", 64'(unexpected_resp), 64'(0));
    reset_in = 1'b0;
    tick();

    // Single Get from M0
    m0_a_valid = 1'b1; m0_a_address = 32'h1000; a_ready_out = 1'b1;
    #1 chk("t1_m0_a_ready", 64'(m0_a_ready), 64'(1));
    tick();
    m0_a_valid = 1'b0;
    chk("t1_a_valid", 64'(a_valid_out), 64'(1));
    chk("t1_a_source", 64'(a_source_out), 64'(0));
    chk("t1_a_address", 64'(a_address_out), 64'(32'h1000));
    tick();
    chk("t1_a_valid_clr", 64'(a_valid_out), 64'(0));
    d_valid_in = 1'b1; d_source_in = 1'b0; d_data_in = 32'hDEAD_BEEF;
    #1 chk("t1_m0_d_valid", 64'(m0_d_valid), 64'(1));
    chk("t1_m1_d_valid", 64'(m1_d_valid), 64'(0));
    chk("t1_m0_d_data", 64'(m0_d_data), 64'(32'hDEAD_BEEF));
    tick();
    d_valid_in = 1'b0;
    tick();

    // Both masters saturate their credits
    do_reset();
    m0_a_valid = 1'b1; m1_a_valid = 1'b1; a_ready_out = 1'b1;
    for (int i = 0; i < 20; i++) begin
      m0_a_address = 32'h100 + 32'(i); m1_a_address = 32'h200 + 32'(i);
      tick();
    end
    chk("t2_m0_grants", 64'(gnt_cnt[0]), 64'(MAXO));
    chk("t2_m1_grants", 64'(gnt_cnt[1]), 64'(MAXO));
    m0_a_valid = 1'b0; m1_a_valid = 1'b0;

    // Back-pressure in HOLD
    do_reset();
    m0_a_valid = 1'b1; m0_a_address = 32'h2000; m1_a_valid = 1'b1; m1_a_address = 32'h3000;
    a_ready_out = 1'b0;
    tick();
    m0_a_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("t3_hold_valid", 64'(a_valid_out), 64'(1));
      chk("t3_hold_addr", 64'(a_address_out), 64'(32'h2000));
      chk("t3_hold_no_grant", 64'(m1_a_ready), 64'(0));
      tick();
    end
    a_ready_out = 1'b1;
    tick();
`ifndef TL_ARB_FIXED_PRIO_EN
    chk("t3_m1_after_release", 64'(m1_a_ready), 64'(1));
`endif
    tick();
    m1_a_valid = 1'b0;
    chk("t3_m1_source", 64'(a_source_out), 64'(1));
    tick();

    // Response for M1 coinciding with a new M1 grant, then unexpected response
    do_reset();
    a_ready_out = 1'b1;
    m1_a_valid = 1'b1; m1_a_address = 32'h4000;
    tick();
    m1_a_valid = 1'b0;
    tick();
    m1_a_valid = 1'b1; m1_a_address = 32'h4004;
    d_valid_in = 1'b1; d_source_in = 1'b1; d_data_in = 32'h1111_2222;
    #1 chk("t4_m1_a_ready", 64'(m1_a_ready), 64'(1));
    chk("t4_m1_d_valid", 64'(m1_d_valid), 64'(1));
    tick();
    m1_a_valid = 1'b0; m1_d_ready = 1'b0;
    #1 chk("t4_d_backpressure", 64'(d_ready_in), 64'(0));
    tick();
    m1_d_ready = 1'b1;
    #1 chk("t4_m1_d_valid_cnt1", 64'(m1_d_valid), 64'(1));
    tick();
    #1 chk("t5_m1_d_valid_zero", 64'(m1_d_valid), 64'(0));
    chk("t5_d_ready_drop", 64'(d_ready_in), 64'(1));
    tick();
    d_valid_in = 1'b0;
    chk("t5_unexpected", 64'(unexpected_resp), 64'(1));
    tick();
    tick();
    chk("t5_unexpected_sticky", 64'(unexpected_resp), 64'(1));

    // Asynchronous reset during HOLD
    do_reset();
    chk("t6_unexpected_clr", 64'(unexpected_resp), 64'(0));
    m0_a_valid = 1'b1; m1_a_valid = 1'b1; a_ready_out = 1'b0;
    m0_a_address = 32'h5000; m1_a_address = 32'h6000;
    tick();
    tick();
    chk("t6_hold_valid", 64'(a_valid_out), 64'(1));
    reset_in = 1'b1;
    #1 chk("t6_async_valid", 64'(a_valid_out), 64'(0));
    chk("t6_async_addr", 64'(a_address_out), 64'(0));
    tick();
    reset_in = 1'b0;
    #1 chk("t6_m0_first", 64'(m0_a_ready), 64'(1));
    chk("t6_m1_blocked", 64'(m1_a_ready), 64'(0));
    a_ready_out = 1'b1;
    tick();
    m0_a_valid = 1'b0; m1_a_valid = 1'b0;
    repeat (4) tick();

    chk("a_queue_empty", 64'(a_q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
